// File: rtl/text_overlay_gen.sv
// Text overlay stage: maps pixel coordinates into an 8-character window, drives the
// font ROM lookup and registers the returned glyph bit into RGB with matching sync delay.
module text_overlay_gen #(
  parameter logic [9:0] TEXT_X0      = 10'd288,
  parameter logic [9:0] TEXT_Y0      = 10'd232,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] FG_RGB       = 8'hFF,
  parameter logic [7:0] BG_RGB       = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [2:0] wr_data,
  input  logic       blink_en,
  output logic [2:0] character_select,
  output logic [3:0] rom_addr,
  output logic [2:0] rom_col,
  input  logic       rom_bit,
  output logic [7:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  // Stage 0: window-relative coordinates
  logic [9:0] dx;
  logic [9:0] dy;
  logic       in_box;
  logic [2:0] idx;
  logic [3:0] row;
  logic [2:0] col;

  assign dx = pixel_x - TEXT_X0;
  assign dy = pixel_y - TEXT_Y0;
  // A non-negative offset with clear upper bits is exactly the 64x16 window.
  assign in_box = (pixel_x >= TEXT_X0) && (pixel_y >= TEXT_Y0) &&
                  (dx[9:6] == 4'd0) && (dy[9:4] == 6'd0);
  assign idx = dx[5:3];
  assign row = dy[3:0];
  assign col = 3'd7 - dx[2:0];

  // Message buffer
  logic [2:0] msg [8];

  // NOTE: the buffer is only eight 3-bit registers with a defined power-up message,
  // so it is reset like any other state rather than left to a RAM macro.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      msg <= '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd5, 3'd0, 3'd0};
    end else if (wr_en) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // Stage 1: font ROM address and delayed side-band
  logic video_on_d1;
  logic in_box_d1;
  logic hsync_d1;
  logic vsync_d1;

  // NOTE: non-blocking assignments here mean the lookup reads msg before any write
  // landing on the same edge, so a same-cycle write to that index shows the old code.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      character_select <= 3'd0;
      rom_addr         <= 4'd0;
      rom_col          <= 3'd0;
      video_on_d1      <= 1'b0;
      in_box_d1        <= 1'b0;
      hsync_d1         <= 1'b1;
      vsync_d1         <= 1'b1;
    end else begin
      character_select <= in_box ? msg[idx] : 3'd0;
      rom_addr         <= in_box ? row      : 4'd0;
      rom_col          <= in_box ? col      : 3'd0;
      video_on_d1      <= video_on;
      in_box_d1        <= in_box;
      hsync_d1         <= hsync_in;
      vsync_d1         <= vsync_in;
    end
  end

  // Blink control, advanced on each falling edge of vsync
  logic [7:0] frame_cnt;
  logic       visible;
  logic       vsync_prev;
  logic       frame_tick;

  assign frame_tick = vsync_prev & ~vsync_in;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt  <= 8'd0;
      visible    <= 1'b1;
      vsync_prev <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (!blink_en) begin
        frame_cnt <= 8'd0;
        visible   <= 1'b1;
      end else if (frame_tick) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt <= 8'd0;
          visible   <= ~visible;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Stage 2: colour and aligned syncs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rgb       <= 8'h00;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      if (!video_on_d1) begin
        rgb <= 8'h00;
      end else if (in_box_d1 && rom_bit && visible) begin
        rgb <= FG_RGB;
      end else begin
        rgb <= BG_RGB;
      end
      hsync_out <= hsync_d1;
      vsync_out <= vsync_d1;
    end
  end

endmodule

// File: tb/tb_text_overlay_gen.sv
// Bench for text_overlay_gen: directed window/buffer/blink/sync cases followed by
// randomized traffic, all compared against a pixel-level reference model.
module tb_text_overlay_gen;

  localparam int         X0 = 288;
  localparam int         Y0 = 232;
  localparam int         BF = 2;
  localparam logic [7:0] FG = 8'hFF;
  localparam logic [7:0] BG = 8'h00;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, hsync_in, vsync_in;
  logic       wr_en;
  logic [2:0] wr_addr, wr_data;
  logic       blink_en;
  logic [2:0] character_select, rom_col;
  logic [3:0] rom_addr;
  logic       rom_bit;
  logic [7:0] rgb;
  logic       hsync_out, vsync_out;
  logic [7:0] rom_row;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] mbuf [8];
  int         edges;
  logic       vs_prev;
  logic [7:0] pend_rgb;
  logic       pend_hs, pend_vs;

  text_overlay_gen #(
    .TEXT_X0(10'd288), .TEXT_Y0(10'd232), .BLINK_FRAMES(BF),
    .FG_RGB(FG), .BG_RGB(BG)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blink_en(blink_en),
    .character_select(character_select), .rom_addr(rom_addr), .rom_col(rom_col),
    .rom_bit(rom_bit), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // Font ROM: code 1 = 'D', code 2 = 'O', codes 3..5 arbitrary, 0/6/7 blank
  function automatic logic [7:0] font_row(input logic [2:0] c, input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (c)
      3'd1: case (r)
              4'd1, 4'd10: v = 8'hF8;
              4'd2, 4'd9:  v = 8'hCC;
              4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: v = 8'hC6;
              default: v = 8'h00;
            endcase
      3'd2: case (r)
              4'd1, 4'd10: v = 8'h7C;
              4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: v = 8'hC6;
              default: v = 8'h00;
            endcase
      3'd3, 3'd4, 3'd5: v = {r, 1'b1, c} ^ 8'h5A;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign rom_row = font_row(character_select, rom_addr);
  assign rom_bit = rom_row[rom_col];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: model predicts, edge happens, outputs compared.
  task automatic tick();
    int         dx, dy, gi;
    logic       ib, gbit, vis;
    logic [2:0] e_cs, e_rc;
    logic [3:0] e_ra;
    logic [7:0] g, now_rgb, next_rgb;
    logic       now_hs, now_vs, next_hs, next_vs;
    if (!reset_n) begin
      mbuf = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd5, 3'd0, 3'd0};
      edges = 0; vs_prev = 1'b1;
      e_cs = 0; e_ra = 0; e_rc = 0;
      now_rgb = 0; now_hs = 1; now_vs = 1;
      next_rgb = 0; next_hs = 1; next_vs = 1;
    end else begin
      now_rgb = pend_rgb; now_hs = pend_hs; now_vs = pend_vs;
      dx = int'(pixel_x) - X0;
      dy = int'(pixel_y) - Y0;
      ib = (dx >= 0) && (dx < 64) && (dy >= 0) && (dy < 16);
      e_cs = 0; e_ra = 0; e_rc = 0; gbit = 1'b0;
      if (ib) begin
        e_cs = mbuf[dx / 8];
        e_ra = 4'(dy);
        e_rc = 3'(7 - dx % 8);
        g = font_row(e_cs, e_ra);
        gi = 7 - dx % 8;
        gbit = g[gi];
      end
      if (!blink_en) edges = 0;
      else if (vs_prev && !vsync_in) edges++;
      vs_prev = vsync_in;
      vis = ((edges / BF) % 2) == 0;
      next_rgb = !video_on ? 8'h00 : ((ib && gbit && vis) ? FG : BG);
      next_hs = hsync_in; next_vs = vsync_in;
      if (wr_en) mbuf[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
    check("cs", 8'(character_select), 8'(e_cs));
    check("rom_addr", 8'(rom_addr), 8'(e_ra));
    check("rom_col", 8'(rom_col), 8'(e_rc));
    check("rgb", rgb, now_rgb);
    check("hsync", 8'(hsync_out), 8'(now_hs));
    check("vsync", 8'(vsync_out), 8'(now_vs));
    pend_rgb = next_rgb; pend_hs = next_hs; pend_vs = next_vs;
  endtask

  task automatic drive(input int x, input int y, input logic von);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    video_on = von;
  endtask

  logic [15:0] pat;

  initial begin
    reset_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; blink_en = 0;
    hsync_in = 1; vsync_in = 1;
    drive(0, 0, 0);
    pend_rgb = 0; pend_hs = 1; pend_vs = 1;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      drive($urandom_range(1023), $urandom_range(1023), 1'($urandom));
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = 3'($urandom);
      tick();
      check("rst_rgb", rgb, 8'h00);
      check("rst_hs", 8'(hsync_out), 8'd1);
    end
    wr_en = 0; hsync_in = 1; vsync_in = 1;
    reset_n = 1;

    // Glyph hit and miss within the first character
    drive(288, 233, 1); tick();
    check("hit_cs", 8'(character_select), 8'd1);
    check("hit_addr", 8'(rom_addr), 8'd1);
    check("hit_col", 8'(rom_col), 8'd7);
    drive(293, 233, 1); tick();
    check("hit_rgb", rgb, 8'hFF);
    check("miss_col", 8'(rom_col), 8'd2);
    tick();
    check("miss_rgb", rgb, 8'h00);

    // Window edges
    drive(287, 233, 1); tick();
    check("left_cs", 8'(character_select), 8'd0);
    tick();
    check("left_rgb", rgb, 8'h00);
    wr_en = 1; wr_addr = 3'd7; wr_data = 3'd5; tick(); wr_en = 0;
    drive(351, 247, 1); tick();
    check("corner_cs", 8'(character_select), 8'd5);
    check("corner_addr", 8'(rom_addr), 8'd15);
    check("corner_col", 8'(rom_col), 8'd0);
    drive(352, 233, 1); tick(); tick();
    check("right_rgb", rgb, 8'h00);
    drive(288, 248, 1); tick(); tick();
    check("below_rgb", rgb, 8'h00);
    drive(288, 233, 0); tick(); tick();
    check("blank_rgb", rgb, 8'h00);

    // Same-cycle write/lookup sees the old code, next cycle the new one
    drive(312, 234, 1);
    wr_en = 1; wr_addr = 3'd3; wr_data = 3'd2; tick(); wr_en = 0;
    check("wr_old_cs", 8'(character_select), 8'd0);
    tick();
    check("wr_new_cs", 8'(character_select), 8'd2);
    check("wr_new_addr", 8'(rom_addr), 8'd2);
    check("wr_new_col", 8'(rom_col), 8'd7);
    check("wr_old_rgb", rgb, 8'h00);
    tick();
    check("wr_new_rgb", rgb, 8'hFF);

    // Blink on a steady glyph pixel
    drive(288, 233, 1); vsync_in = 1; repeat (3) tick();
    blink_en = 1;
    for (int f = 1; f <= 6; f++) begin
      vsync_in = 0; tick(); tick();
      vsync_in = 1; repeat (3) tick();
      if (f == 2) check("blink_off", rgb, 8'h00);
      if (f == 4) check("blink_on", rgb, 8'hFF);
      if (f == 6) check("blink_off2", rgb, 8'h00);
    end
    blink_en = 0; tick(); tick();
    check("blink_drop", rgb, 8'hFF);

    // Sync pattern reproduced two clocks later
    pat = 16'b1011_0011_1101_1110;
    for (int i = 0; i < 16; i++) begin
      hsync_in = pat[i]; vsync_in = ~pat[i];
      tick();
      if (i >= 1) check("hs_pat", 8'(hsync_out), 8'(pat[i-1]));
    end
    hsync_in = 1; vsync_in = 1;

    // Reset mid-line
    drive(300, 240, 1); tick(); tick();
    reset_n = 0; tick();
    check("mid_rst_rgb", rgb, 8'h00);
    check("mid_rst_cs", 8'(character_select), 8'd0);
    reset_n = 1; drive(288, 233, 1); tick();
    check("post_rst_rgb", rgb, 8'h00);
    tick();
    check("post_rst_hit", rgb, 8'hFF);

    // Randomized traffic around the window
    for (int i = 0; i < 3000; i++) begin
      drive(X0 - 20 + int'($urandom_range(109)), Y0 - 8 + int'($urandom_range(29)),
            $urandom_range(7) != 0);
      hsync_in = $urandom_range(3) != 0;
      vsync_in = $urandom_range(2) != 0;
      wr_en    = $urandom_range(5) == 0;
      wr_addr  = 3'($urandom);
      wr_data  = 3'($urandom);
      if ($urandom_range(99) == 0) blink_en = ~blink_en;
      reset_n  = $urandom_range(149) != 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_overlay_gen.md
Name: text_overlay_gen

Overview:
- Character-generation stage sitting between the VGA sync/pixel-counter block and the font ROM.
- Maps the current pixel coordinate onto an 8-character text window.
- Looks each character up in a writable message buffer and drives character_select, rom_addr and rom_col into the font ROM.
- Registers the returned rom_bit into RGB, keeping hsync/vsync aligned with that pixel. Also provides frame-rate blinking.

Parameters:
TEXT_X0, 288, left pixel column of text window (10-bit)
TEXT_Y0, 232, top pixel row of text window (10-bit)
BLINK_FRAMES, 30, frames per blink half-period (1..255)
FG_RGB, 8'hFF, foreground colour, RRRGGGBB
BG_RGB, 8'h00, background colour inside active video

Ports:
clk  in  1  pixel clock
reset_n  in  1  synchronous, active-low reset
pixel_x  in  10  current pixel column from sync generator
pixel_y  in  10  current pixel row from sync generator
video_on  in  1  1 = active display area
hsync_in  in  1  horizontal sync, active-low
vsync_in  in  1  vertical sync, active-low
wr_en  in  1  message buffer write strobe
wr_addr  in  3  message buffer index
wr_data  in  3  character code to store
blink_en  in  1  1 = text blinks
character_select  out  3  to font ROM: character code
rom_addr  out  4  to font ROM: glyph row
rom_col  out  3  to font ROM: glyph bit index
rom_bit  in  1  from font ROM, combinational on the three outputs above
rgb  out  8  pixel colour
hsync_out  out  1  hsync delayed to align with rgb
vsync_out  out  1  vsync delayed to align with rgb

Behaviour:
- Single clock domain. Reset is synchronous and active-low, sampled on posedge clk, and takes priority over everything else.
- Reset values:
  - character_select, rom_addr, rom_col = 0.
  - rgb = 0.
  - hsync_out = vsync_out = 1.
  - Internal pipeline valid/in_box flags = 0, sync delay regs = 1.
  - frame_cnt = 0, visible = 1, vsync_prev = 1.
  - Message buffer [0..7] = 1,2,3,0,4,5,0,0.
- Stage 0 (combinational on inputs):
  - dx = pixel_x - TEXT_X0, dy = pixel_y - TEXT_Y0 (10-bit).
  - in_box = (pixel_x >= TEXT_X0) && (pixel_x < TEXT_X0+64) && (pixel_y >= TEXT_Y0) && (pixel_y < TEXT_Y0+16).
  - idx = dx[5:3], row = dy[3:0], col = 3'd7 - dx[2:0]. Glyph bit 7 is the leftmost pixel.
- Stage 1 (register):
  - in_box: character_select = buf[idx], rom_addr = row, rom_col = col.
  - Not in_box: character_select = 0, rom_addr = 0, rom_col = 0.
  - video_on, in_box, hsync_in, vsync_in are delayed one cycle alongside.
- Stage 2 (register):
  - rgb = 0 if video_on_d1 = 0.
  - Otherwise rgb = FG_RGB if (in_box_d1 && rom_bit && visible), else BG_RGB.
  - hsync_out/vsync_out = sync delayed 2 cycles.
- Latency: exactly 2 clocks from pixel_x/pixel_y/video_on/syncs to rgb/hsync_out/vsync_out, constant for every pixel.
- Message buffer:
  - wr_en high at posedge writes buf[wr_addr] = wr_data.
  - A Stage 1 lookup in the same cycle as a write to the same index uses the old value. The new value applies from the next cycle.
  - Codes 6 and 7 are stored as-is; the font returns blank for them.
- Blink:
  - frame_tick = vsync_prev & ~vsync_in (falling edge); vsync_prev <= vsync_in every cycle.
  - blink_en = 1: on frame_tick, if frame_cnt == BLINK_FRAMES-1 then frame_cnt <= 0 and visible toggles; otherwise frame_cnt++.
  - blink_en = 0: frame_cnt <= 0, visible <= 1.
- Boundaries:
  - pixel_x < TEXT_X0 causes dx underflow, which in_box masks out.
  - Columns TEXT_X0+64 and beyond, and row TEXT_Y0+16, are outside the window.
  - Reset asserted mid-frame forces outputs to reset values on the next edge. After release, valid output resumes 2 cycles later with no stale pixel.

Test Plan:
- Reset check: hold reset_n=0 with random inputs for 4 clocks -> rgb=00, hsync_out=vsync_out=1, character_select/rom_addr/rom_col=0, throughout.
- Glyph hit: pixel (288,233), video_on=1, with bench font model (D row1 = 11111000) -> next cycle character_select=1, rom_addr=1, rom_col=7; rgb=FF 2 clocks after input. Pixel (293,233) -> rom_col=2, rgb=00.
- Window edges:
  - (287,233) -> character_select=0, rgb=00.
  - (351,247) -> in_box, idx=7.
  - (352,233) and (288,248) -> outside, rgb=00.
  - video_on=0 at (288,233) -> rgb=00.
- Buffer write: write wr_addr=3, wr_data=2, then pixel (312,234) -> character_select=2, rom_addr=2, rom_col=7, rgb=FF (O row2 = 11000110). Write and lookup of idx 3 in the same cycle -> old code 0, rgb=00.
- Blink: BLINK_FRAMES=2, blink_en=1, steady glyph pixel -> after 2 vsync falling edges rgb FF->00, after 2 more ->FF. Drop blink_en -> rgb=FF within the next frame.
- Sync alignment: toggle hsync_in/vsync_in at known cycles -> hsync_out/vsync_out reproduce the pattern delayed exactly 2 clocks. Reset asserted mid-line -> pipeline clears, resumes correctly.
